// File: rtl/psram_spi_responder.sv
// SPI-mode PSRAM command responder: oversamples the initiator's pins on sys_clk,
// decodes reset/read/write/read-ID commands and serves data from a small byte array.
module psram_spi_responder #(
    parameter int          ADDR_BITS = 8,
    parameter logic [15:0] ID_WORD   = 16'h0D5D
) (
    input  logic       sys_clk,
    input  logic       sys_reset_n,
    input  logic       spi_ce_n,
    input  logic       spi_clk,
    input  logic       spi_si,
    output logic       spi_so,
    output logic       spi_so_oe,
    output logic       cmd_strobe,
    output logic [7:0] cmd_byte,
    output logic       reset_pulse,
    output logic       bad_cmd
);
    localparam int DEPTH = 1 << ADDR_BITS;

    typedef enum logic [2:0] {S_IDLE, S_CMD, S_ADDR, S_RDATA, S_WDATA, S_IDOUT, S_HOLD, S_IGNORE} state_t;
    typedef enum logic [1:0] {OP_RD, OP_WR, OP_ID} op_t;

    logic ce_meta_q, ce_sync_q, ce_prev_q, ce_fall_q, ce_rise_q;
    logic ce_meta_d, ce_sync_d, ce_prev_d, ce_fall_d, ce_rise_d;
    logic clk_meta_q, clk_sync_q, clk_prev_q, rise_evt_q, fall_evt_q;
    logic clk_meta_d, clk_sync_d, clk_prev_d, rise_evt_d, fall_evt_d;
    logic si_meta_q, si_sync_q, si_bit_q;
    logic si_meta_d, si_sync_d, si_bit_d;

    state_t                 state_q, state_d;
    op_t                    op_q, op_d;
    logic [4:0]             bit_cnt_q, bit_cnt_d;
    logic [6:0]             in_sh_q, in_sh_d;
    logic [ADDR_BITS-1:0]   addr_q, addr_d;
    logic [7:0]             out_sh_q, out_sh_d;
    logic [2:0]             out_cnt_q, out_cnt_d;
    logic [1:0]             id_idx_q, id_idx_d;
    logic                   so_q, so_d, oe_q, oe_d;
    logic                   cmd_strobe_q, cmd_strobe_d;
    logic [7:0]             cmd_byte_q, cmd_byte_d;
    logic                   reset_pulse_q, reset_pulse_d;
    logic                   bad_cmd_q, bad_cmd_d;
    logic                   rst_armed_q, rst_armed_d;

    logic [7:0] mem [0:DEPTH-1];
    logic [7:0] rd_data_q;
    logic       mem_we;
    logic [7:0] byte_in, load_byte, id_byte;
    logic       exact8;

    always_comb begin
        ce_meta_d  = spi_ce_n;
        ce_sync_d  = ce_meta_q;
        ce_prev_d  = ce_sync_q;
        ce_fall_d  = ce_prev_q & ~ce_sync_q;
        ce_rise_d  = ~ce_prev_q & ce_sync_q;
        clk_meta_d = spi_clk;
        clk_sync_d = clk_meta_q;
        clk_prev_d = clk_sync_q;
        rise_evt_d = clk_sync_q & ~clk_prev_q;
        fall_evt_d = ~clk_sync_q & clk_prev_q;
        si_meta_d  = spi_si;
        si_sync_d  = si_meta_q;
        si_bit_d   = si_sync_q;
    end

    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        bit_cnt_d     = bit_cnt_q;
        in_sh_d       = in_sh_q;
        addr_d        = addr_q;
        out_sh_d      = out_sh_q;
        out_cnt_d     = out_cnt_q;
        id_idx_d      = id_idx_q;
        so_d          = so_q;
        oe_d          = oe_q;
        cmd_strobe_d  = 1'b0;
        cmd_byte_d    = cmd_byte_q;
        reset_pulse_d = 1'b0;
        bad_cmd_d     = 1'b0;
        rst_armed_d   = rst_armed_q;
        mem_we        = 1'b0;
        exact8        = 1'b0;
        byte_in       = {in_sh_q, si_bit_q};
        load_byte     = 8'h00;
        case (id_idx_q)
            2'd0:    id_byte = ID_WORD[15:8];
            2'd1:    id_byte = ID_WORD[7:0];
            default: id_byte = 8'h00;
        endcase

        if (rise_evt_q && state_q != S_IDLE) begin
            in_sh_d   = byte_in[6:0];
            bit_cnt_d = bit_cnt_q + 5'd1;
            case (state_q)
                S_CMD: if (bit_cnt_q == 5'd7) begin
                    cmd_strobe_d = 1'b1;
                    cmd_byte_d   = byte_in;
                    bit_cnt_d    = 5'd0;
                    case (byte_in)
                        8'h03:        begin state_d = S_ADDR; op_d = OP_RD; end
                        8'h02:        begin state_d = S_ADDR; op_d = OP_WR; end
                        8'h9F:        begin state_d = S_ADDR; op_d = OP_ID; end
                        8'h66, 8'h99: state_d = S_HOLD;
                        default:      begin state_d = S_IGNORE; bad_cmd_d = 1'b1; end
                    endcase
                end
                S_ADDR: begin
                    addr_d = {addr_q[ADDR_BITS-2:0], si_bit_q};
                    if (bit_cnt_q == 5'd23) begin
                        bit_cnt_d = 5'd0;
                        case (op_q)
                            OP_RD:   state_d = S_RDATA;
                            OP_WR:   state_d = S_WDATA;
                            default: state_d = S_IDOUT;
                        endcase
                    end
                end
                S_WDATA: if (bit_cnt_q == 5'd7) begin
                    mem_we    = 1'b1;
                    addr_d    = addr_q + 1'b1;
                    bit_cnt_d = 5'd0;
                end
                // Any bit after the opcode disqualifies a reset-sequence byte.
                S_HOLD:  bit_cnt_d = 5'd1;
                default: ;
            endcase
        end

        if (fall_evt_q && (state_q == S_RDATA || state_q == S_IDOUT)) begin
            oe_d      = 1'b1;
            out_cnt_d = out_cnt_q + 3'd1;
            if (out_cnt_q == 3'd0) begin
                load_byte = (state_q == S_RDATA) ? rd_data_q : id_byte;
                so_d      = load_byte[7];
                out_sh_d  = {load_byte[6:0], 1'b0};
                if (state_q == S_RDATA)
                    addr_d = addr_q + 1'b1;
                else if (id_idx_q != 2'd2)
                    id_idx_d = id_idx_q + 2'd1;
            end else begin
                so_d     = out_sh_q[7];
                out_sh_d = {out_sh_q[6:0], 1'b0};
            end
        end

        // Evaluated on the post-bit values so a coincident last bit still counts.
        if (ce_rise_q) begin
            exact8        = (state_d == S_HOLD) && (bit_cnt_d == 5'd0);
            reset_pulse_d = rst_armed_q && exact8 && (cmd_byte_d == 8'h99);
            rst_armed_d   = exact8 && (cmd_byte_d == 8'h66);
            state_d       = S_IDLE;
            bit_cnt_d     = 5'd0;
            out_cnt_d     = 3'd0;
            id_idx_d      = 2'd0;
            in_sh_d       = 7'd0;
            so_d          = 1'b0;
            oe_d          = 1'b0;
        end else if (ce_fall_q && state_q == S_IDLE) begin
            state_d   = S_CMD;
            bit_cnt_d = 5'd0;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            ce_meta_q <= 1'b1; ce_sync_q <= 1'b1; ce_prev_q <= 1'b1;
            ce_fall_q <= 1'b0; ce_rise_q <= 1'b0;
            clk_meta_q <= 1'b0; clk_sync_q <= 1'b0; clk_prev_q <= 1'b0;
            rise_evt_q <= 1'b0; fall_evt_q <= 1'b0;
            si_meta_q <= 1'b0; si_sync_q <= 1'b0; si_bit_q <= 1'b0;
            state_q       <= S_IDLE;
            op_q          <= OP_RD;
            bit_cnt_q     <= 5'd0;
            in_sh_q       <= 7'd0;
            addr_q        <= '0;
            out_sh_q      <= 8'h00;
            out_cnt_q     <= 3'd0;
            id_idx_q      <= 2'd0;
            so_q          <= 1'b0;
            oe_q          <= 1'b0;
            cmd_strobe_q  <= 1'b0;
            cmd_byte_q    <= 8'h00;
            reset_pulse_q <= 1'b0;
            bad_cmd_q     <= 1'b0;
            rst_armed_q   <= 1'b0;
        end else begin
            ce_meta_q <= ce_meta_d; ce_sync_q <= ce_sync_d; ce_prev_q <= ce_prev_d;
            ce_fall_q <= ce_fall_d; ce_rise_q <= ce_rise_d;
            clk_meta_q <= clk_meta_d; clk_sync_q <= clk_sync_d; clk_prev_q <= clk_prev_d;
            rise_evt_q <= rise_evt_d; fall_evt_q <= fall_evt_d;
            si_meta_q <= si_meta_d; si_sync_q <= si_sync_d; si_bit_q <= si_bit_d;
            state_q       <= state_d;
            op_q          <= op_d;
            bit_cnt_q     <= bit_cnt_d;
            in_sh_q       <= in_sh_d;
            addr_q        <= addr_d;
            out_sh_q      <= out_sh_d;
            out_cnt_q     <= out_cnt_d;
            id_idx_q      <= id_idx_d;
            so_q          <= so_d;
            oe_q          <= oe_d;
            cmd_strobe_q  <= cmd_strobe_d;
            cmd_byte_q    <= cmd_byte_d;
            reset_pulse_q <= reset_pulse_d;
            bad_cmd_q     <= bad_cmd_d;
            rst_armed_q   <= rst_armed_d;
        end
    end

    // Array contents survive reset, so this port has no reset branch.
    always_ff @(posedge sys_clk) begin
        if (mem_we)
            mem[addr_q] <= byte_in;
        rd_data_q <= mem[addr_q];
    end

    assign spi_so      = so_q;
    assign spi_so_oe   = oe_q;
    assign cmd_strobe  = cmd_strobe_q;
    assign cmd_byte    = cmd_byte_q;
    assign reset_pulse = reset_pulse_q;
    assign bad_cmd     = bad_cmd_q;
endmodule
